mc_controller_hs: RTL
=====================

# mc_controller_hs

Multicycle RV32I control unit with memory handshaking. It sits between the datapath (ALU flags, instruction fields) and a shared instruction/data memory that may insert wait states. It sequences fetch, decode, execute, memory and writeback and drives every datapath select and enable. Compared with the fixed-latency controller it adds:

- ready-based memory stalls
- full signed and unsigned branch support
- shift operations
- an illegal-instruction trap state
- a retired-instruction counter
- optional multiply/divide sequencing

## Interface
Parameters:
- ALUOP_W, 4: width of `aluop`; must be ≥4.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- op  in  7  instruction opcode.
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- md_done  in  1  mul/div unit result valid (only with CTRL_MULDIV_EN).
- pc_en  out  1  PC write enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU register.
- mem_req  out  1  memory request.
- mem_write  out  1  request is a write.
- ir_write  out  1  instruction register and old-PC capture.
- reg_write  out  1  register file write.
- alusrc_a  out  2  ALU A select: 0 = PC, 1 = old PC, 2 = rs1.
- alusrc_b  out  2  ALU B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- aluop  out  ALUOP_W  ALU operation.
- result_src  out  2  result select: 0 = ALU register, 1 = ALU, 2 = MDR, 3 = immediate.
- imm_src  out  3  immediate format: I, S, B, J, U = 0..4.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- halted  out  1  core stopped on an illegal instruction.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: IF, ID, EX_R, EX_I, EX_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MDR, WB_U, EX_JAL, EX_JALR, LINK, EX_B, MD_WAIT, TRAP.
- IF:
  - Drives mem_req=1, adr_src=0, ALU = PC+4, result_src=1.
  - pc_en and ir_write are asserted only in a cycle where mem_ready=1; that same cycle advances to ID. Otherwise the FSM stays in IF.
- ID:
  - Computes old PC + B-immediate into the ALU register.
  - Dispatches on op: 0110011→EX_R, 0010011→EX_I, 0000011/0100011→EX_ADDR, 1100011→EX_B, 1101111→EX_JAL, 1100111→EX_JALR, 0110111→WB_U.
  - Any other op goes to TRAP.
- EX_R and EX_I decode func3/func7 to:
  - add, sub, and, or, xor, slt, sltu
  - sll, srl, sra (func7=0100000 selects sra/sub)
  - An unlisted func7/func3 combination goes to TRAP.
  - Both go to WB_ALU.
- EX_ADDR:
  - Computes rs1 + imm: I-format for loads, S-format for stores.
  - Then goes to MEM_RD for loads or MEM_WR for stores.
- MEM_RD and MEM_WR:
  - Drive mem_req=1 and adr_src=1; MEM_WR also drives mem_write=1.
  - Hold until mem_ready=1. MEM_RD then goes to WB_MDR; MEM_WR goes to IF.
- EX_B:
  - Performs sub; pc_en is the taken condition.
  - func3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; any other func3 goes to TRAP.
  - Then goes to IF.
- Jumps:
  - EX_JAL computes old PC + J-immediate; EX_JALR computes rs1 + I-immediate. Both then go to LINK.
  - LINK loads the PC from the ALU register and computes old PC + 4. Then WB_ALU.
- Writeback: WB_ALU, WB_MDR and WB_U assert reg_write with result_src 0, 2 and 3 (U-immediate) respectively, then go to IF.
- Retirement:
  - instret increments by 1 on the final cycle of each instruction: WB_*, MEM_WR accepted, or EX_B.
  - It wraps modulo 2^CNT_W.
- TRAP: halted=1 and all enables are 0; the FSM stays in TRAP until reset.

## Timing
- Reset:
  - While rst=0 at an edge, the state becomes IF and instret becomes 0.
  - While rst=0, all outputs are forced to 0, including mem_req and halted.
  - Reset during a memory wait abandons the request; mem_req is low during reset.
- Zero-wait memory latencies:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - lui: 3 cycles.
  - jal/jalr: 5 cycles.
- Each cycle with mem_ready=0 adds one cycle.
- mem_ready is ignored in any cycle where mem_req=0.
- Outputs are combinational from the state and instruction fields; they carry no registered delay.

## Configuration
- CTRL_MULDIV_EN:
  - Defined: func7=0000001 in EX_R pulses md_start for one cycle, then the FSM enters MD_WAIT. It holds there until md_done=1, then goes to WB_ALU with result_src=1.
  - Undefined: md_start is tied to 0, md_done is unused, and func7=0000001 goes to TRAP.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum
  - the opcode, func3 and func7 constants
  - aluop codes: add 0, sub 1, and 2, or 3, slt 4, sltu 5, xor 6, sll 7, srl 8, sra 9
  - the select encodings
- One sub-module, mc_alu_decode: combinational mapping of func3/func7 to aluop and a legal flag, shared by EX_R and EX_I.

## Test plan
- add x3,x1,x2 with mem_ready always 1 → ID reached 1 cycle after reset; reg_write in cycle 4; instret=1.
- lw with mem_ready low for 3 cycles in MEM_RD → mem_req held 4 cycles; WB_MDR asserts result_src=2; load completes in 8 cycles.
- bltu with ltu=1 then bgeu with ltu=1 → pc_en=1 in EX_B for the first and 0 for the second; both retire.
- op=1111111 → TRAP with halted=1; 10 further cycles leave instret unchanged; rst=0 for one edge → IF, halted=0.
- rst=0 asserted while in MEM_WR waiting → next state IF, mem_write=0 during reset, instret=0.
- CTRL_MULDIV_EN defined, mul with md_done after 5 cycles → md_start high exactly 1 cycle; reg_write 1 cycle after md_done. Without the macro, the same instruction → TRAP.

Source files
------------

// File: rtl/mc_controller_hs_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU,
    S_WB_MDR, S_WB_U, S_EX_JAL, S_EX_JALR, S_LINK, S_EX_B, S_MD_WAIT, S_TRAP
  } state_e;

  // Opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // ALU func3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch func3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // func7
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Datapath select encodings
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;
  localparam logic [1:0] ASRC_PC    = 2'd0;
  localparam logic [1:0] ASRC_OLDPC = 2'd1;
  localparam logic [1:0] ASRC_RS1   = 2'd2;
  localparam logic [1:0] BSRC_RS2   = 2'd0;
  localparam logic [1:0] BSRC_IMM   = 2'd1;
  localparam logic [1:0] BSRC_FOUR  = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_ALU    = 2'd1;
  localparam logic [1:0] RES_MDR    = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;
  localparam logic [2:0] IMM_I      = 3'd0;
  localparam logic [2:0] IMM_S      = 3'd1;
  localparam logic [2:0] IMM_B      = 3'd2;
  localparam logic [2:0] IMM_J      = 3'd3;
  localparam logic [2:0] IMM_U      = 3'd4;

endpackage

// File: rtl/mc_controller_hs_if.sv
// Datapath/memory control bundle between the controller (master) and datapath (slave).
interface mc_ctrl_if #(parameter int ALUOP_W = 4) ();
  logic [6:0]         op;
  logic [2:0]         func3;
  logic [6:0]         func7;
  logic               zero;
  logic               lt;
  logic               ltu;
  logic               mem_ready;
  logic               md_done;
  logic               pc_en;
  logic               adr_src;
  logic               mem_req;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         alusrc_a;
  logic [1:0]         alusrc_b;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         result_src;
  logic [2:0]         imm_src;
  logic               md_start;

  modport master (
    input  op, func3, func7, zero, lt, ltu, mem_ready, md_done,
    output pc_en, adr_src, mem_req, mem_write, ir_write, reg_write,
           alusrc_a, alusrc_b, aluop, result_src, imm_src, md_start
  );

  modport slave (
    output op, func3, func7, zero, lt, ltu, mem_ready, md_done,
    input  pc_en, adr_src, mem_req, mem_write, ir_write, reg_write,
           alusrc_a, alusrc_b, aluop, result_src, imm_src, md_start
  );
endinterface

// File: rtl/mc_controller_hs_alu_decode.sv
// func3/func7 to ALU operation decode shared by register and immediate ops.
// In immediate mode func7 is immediate data except for the shift encodings.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       imm_mode,
  output logic [3:0] aluop,
  output logic       legal
);

  logic plain_ok_s;
  assign plain_ok_s = imm_mode | (func7 == F7_BASE);

  // Map func3/func7 to an ALU operation and flag unsupported encodings.
  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b0;
    case (func3)
      F3_ADD: begin
        if (plain_ok_s) begin
          aluop = ALU_ADD;
          legal = 1'b1;
        end else if (func7 == F7_ALT) begin
          aluop = ALU_SUB;
          legal = 1'b1;
        end else begin
          aluop = ALU_ADD;
          legal = 1'b0;
        end
      end
      F3_SLL:  begin aluop = ALU_SLL;  legal = (func7 == F7_BASE); end
      F3_SLT:  begin aluop = ALU_SLT;  legal = plain_ok_s; end
      F3_SLTU: begin aluop = ALU_SLTU; legal = plain_ok_s; end
      F3_XOR:  begin aluop = ALU_XOR;  legal = plain_ok_s; end
      F3_OR:   begin aluop = ALU_OR;   legal = plain_ok_s; end
      F3_AND:  begin aluop = ALU_AND;  legal = plain_ok_s; end
      F3_SR: begin
        if (func7 == F7_BASE) begin
          aluop = ALU_SRL;
          legal = 1'b1;
        end else if (func7 == F7_ALT) begin
          aluop = ALU_SRA;
          legal = 1'b1;
        end else begin
          aluop = ALU_SRL;
          legal = 1'b0;
        end
      end
      default: begin
        aluop = ALU_ADD;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control unit with ready-based memory handshaking.
// Optional feature macro: CTRL_MULDIV_EN (mul/div sequencing via MD_WAIT).
// Outputs are combinational from state and instruction fields and are
// forced low while rst is asserted (low).
module mc_controller_hs
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_if.master        bus,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_e           state_r, state_next_s;
  logic [CNT_W-1:0] instret_r;
  logic             pc_en_s, adr_src_s, mem_req_s, mem_write_s, ir_write_s, reg_write_s;
  logic [1:0]       alusrc_a_s, alusrc_b_s, result_src_s;
  logic [2:0]       imm_src_s;
  logic [3:0]       aluop_s, dec_aluop_s;
  logic             dec_legal_s, md_start_s, halted_s, retire_s, taken_s, br_legal_s;

  mc_alu_decode u_alu_decode (
    .func3    (bus.func3),
    .func7    (bus.func7),
    .imm_mode (state_r == S_EX_I),
    .aluop    (dec_aluop_s),
    .legal    (dec_legal_s)
  );

`ifdef CTRL_MULDIV_EN
  logic md_wb_r;

  // Remember that the pending writeback comes from the mul/div unit.
  always_ff @(posedge clk) begin
    if (!rst)                                     md_wb_r <= 1'b0;
    else if (md_start_s)                          md_wb_r <= 1'b1;
    else if (state_r == S_WB_ALU)                 md_wb_r <= 1'b0;
    else                                          md_wb_r <= md_wb_r;
  end
`else
  logic unused_md_done_s;
  assign unused_md_done_s = bus.md_done;
`endif

  // Branch condition from func3 and ALU comparison flags.
  always_comb begin
    taken_s    = 1'b0;
    br_legal_s = 1'b1;
    case (bus.func3)
      F3_BEQ:  taken_s = bus.zero;
      F3_BNE:  taken_s = ~bus.zero;
      F3_BLT:  taken_s = bus.lt;
      F3_BGE:  taken_s = ~bus.lt;
      F3_BLTU: taken_s = bus.ltu;
      F3_BGEU: taken_s = ~bus.ltu;
      default: br_legal_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= S_IF;
    else      state_r <= state_next_s;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst)          instret_r <= {CNT_W{1'b0}};
    else if (retire_s) instret_r <= instret_r + CNT_W'(1'b1);
    else               instret_r <= instret_r;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next_s = state_r;
    pc_en_s      = 1'b0;
    adr_src_s    = ADR_PC;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alusrc_a_s   = ASRC_PC;
    alusrc_b_s   = BSRC_RS2;
    result_src_s = RES_ALUOUT;
    imm_src_s    = IMM_I;
    aluop_s      = ALU_ADD;
    md_start_s   = 1'b0;
    halted_s     = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_IF: begin
        mem_req_s    = 1'b1;
        alusrc_b_s   = BSRC_FOUR;
        result_src_s = RES_ALU;
        if (bus.mem_ready) begin
          pc_en_s      = 1'b1;
          ir_write_s   = 1'b1;
          state_next_s = S_ID;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_ID: begin
        alusrc_a_s = ASRC_OLDPC;
        alusrc_b_s = BSRC_IMM;
        imm_src_s  = IMM_B;
        case (bus.op)
          OP_R:     state_next_s = S_EX_R;
          OP_I:     state_next_s = S_EX_I;
          OP_LOAD:  state_next_s = S_EX_ADDR;
          OP_STORE: state_next_s = S_EX_ADDR;
          OP_BR:    state_next_s = S_EX_B;
          OP_JAL:   state_next_s = S_EX_JAL;
          OP_JALR:  state_next_s = S_EX_JALR;
          OP_LUI:   state_next_s = S_WB_U;
          default:  state_next_s = S_TRAP;
        endcase
      end
      S_EX_R: begin
        alusrc_a_s = ASRC_RS1;
        alusrc_b_s = BSRC_RS2;
        aluop_s    = dec_aluop_s;
`ifdef CTRL_MULDIV_EN
        if (bus.func7 == F7_MULDIV) begin
          md_start_s   = 1'b1;
          state_next_s = S_MD_WAIT;
        end else if (dec_legal_s) begin
          state_next_s = S_WB_ALU;
        end else begin
          state_next_s = S_TRAP;
        end
`else
        if (dec_legal_s) state_next_s = S_WB_ALU;
        else             state_next_s = S_TRAP;
`endif
      end
      S_EX_I: begin
        alusrc_a_s = ASRC_RS1;
        alusrc_b_s = BSRC_IMM;
        imm_src_s  = IMM_I;
        aluop_s    = dec_aluop_s;
        if (dec_legal_s) state_next_s = S_WB_ALU;
        else             state_next_s = S_TRAP;
      end
      S_EX_ADDR: begin
        alusrc_a_s = ASRC_RS1;
        alusrc_b_s = BSRC_IMM;
        if (bus.op == OP_LOAD) begin
          imm_src_s    = IMM_I;
          state_next_s = S_MEM_RD;
        end else begin
          imm_src_s    = IMM_S;
          state_next_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_req_s = 1'b1;
        adr_src_s = ADR_ALU;
        if (bus.mem_ready) state_next_s = S_WB_MDR;
        else               state_next_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_req_s   = 1'b1;
        adr_src_s   = ADR_ALU;
        mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          retire_s     = 1'b1;
          state_next_s = S_IF;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_WB_ALU: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
`ifdef CTRL_MULDIV_EN
        result_src_s = md_wb_r ? RES_ALU : RES_ALUOUT;
`else
        result_src_s = RES_ALUOUT;
`endif
        state_next_s = S_IF;
      end
      S_WB_MDR: begin
        reg_write_s  = 1'b1;
        result_src_s = RES_MDR;
        retire_s     = 1'b1;
        state_next_s = S_IF;
      end
      S_WB_U: begin
        reg_write_s  = 1'b1;
        result_src_s = RES_IMM;
        imm_src_s    = IMM_U;
        retire_s     = 1'b1;
        state_next_s = S_IF;
      end
      S_EX_JAL: begin
        alusrc_a_s   = ASRC_OLDPC;
        alusrc_b_s   = BSRC_IMM;
        imm_src_s    = IMM_J;
        state_next_s = S_LINK;
      end
      S_EX_JALR: begin
        alusrc_a_s   = ASRC_RS1;
        alusrc_b_s   = BSRC_IMM;
        imm_src_s    = IMM_I;
        state_next_s = S_LINK;
      end
      S_LINK: begin
        pc_en_s      = 1'b1;
        result_src_s = RES_ALUOUT;
        alusrc_a_s   = ASRC_OLDPC;
        alusrc_b_s   = BSRC_FOUR;
        state_next_s = S_WB_ALU;
      end
      S_EX_B: begin
        alusrc_a_s = ASRC_RS1;
        alusrc_b_s = BSRC_RS2;
        aluop_s    = ALU_SUB;
        if (br_legal_s) begin
          pc_en_s      = taken_s;
          retire_s     = 1'b1;
          state_next_s = S_IF;
        end else begin
          state_next_s = S_TRAP;
        end
      end
      S_MD_WAIT: begin
`ifdef CTRL_MULDIV_EN
        result_src_s = RES_ALU;
        if (bus.md_done) state_next_s = S_WB_ALU;
        else             state_next_s = S_MD_WAIT;
`else
        state_next_s = S_TRAP;
`endif
      end
      S_TRAP: begin
        halted_s     = 1'b1;
        state_next_s = S_TRAP;
      end
      default: state_next_s = S_TRAP;
    endcase
  end

  // Reset forces every output low, abandoning any pending memory request.
  assign bus.pc_en      = rst & pc_en_s;
  assign bus.adr_src    = rst & adr_src_s;
  assign bus.mem_req    = rst & mem_req_s;
  assign bus.mem_write  = rst & mem_write_s;
  assign bus.ir_write   = rst & ir_write_s;
  assign bus.reg_write  = rst & reg_write_s;
  assign bus.md_start   = rst & md_start_s;
  assign bus.alusrc_a   = rst ? alusrc_a_s   : 2'd0;
  assign bus.alusrc_b   = rst ? alusrc_b_s   : 2'd0;
  assign bus.result_src = rst ? result_src_s : 2'd0;
  assign bus.imm_src    = rst ? imm_src_s    : 3'd0;
  assign bus.aluop      = rst ? ALUOP_W'(aluop_s) : {ALUOP_W{1'b0}};
  assign halted         = rst & halted_s;
  assign instret        = rst ? instret_r : {CNT_W{1'b0}};

endmodule
